// File: rtl/daq_sweep_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : daq_sweep_sequencer
// Purpose  : Steps a DAC code over N points and averages 2^k DAQ reads per point.
// Revision : 1.0
// ============================================================================
module daq_sweep_sequencer #(
    parameter int DATA_W = 12,
    parameter int CNT_W  = 8,
    parameter int GAP_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sweep_start,
    input  logic              abort,
    input  logic [DATA_W-1:0] cfg_start_code,
    input  logic [DATA_W-1:0] cfg_step,
    input  logic [CNT_W-1:0]  cfg_num_points,
    input  logic [2:0]        cfg_avg_log2,
    input  logic [GAP_W-1:0]  cfg_gap,
    output logic              daq_start,
    output logic [DATA_W-1:0] daq_dac_code,
    input  logic              daq_adc_valid,
    input  logic [DATA_W-1:0] daq_adc_data,
    input  logic              daq_done,
    output logic              result_valid,
    output logic [DATA_W-1:0] result_data,
    output logic [CNT_W-1:0]  result_index,
    output logic              busy,
    output logic              sweep_done,
    output logic              missed_sample
);

    localparam int ACC_W = DATA_W + 7;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_WAIT_DONE = 3'd2;
    localparam logic [2:0] S_GAP       = 3'd3;
    localparam logic [2:0] S_EMIT      = 3'd4;
    localparam logic [2:0] S_FINISH    = 3'd5;
    localparam logic [2:0] S_DRAIN     = 3'd6;

    logic [2:0]        r_state;
    logic [DATA_W-1:0] r_code;
    logic [DATA_W-1:0] r_step;
    logic [CNT_W-1:0]  r_num_points;
    logic [CNT_W-1:0]  r_index;
    logic [2:0]        r_avg_log2;
    logic [GAP_W-1:0]  r_gap;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [ACC_W-1:0]  r_acc;
    logic [7:0]        r_samples;
    logic              r_got_valid;
    logic [DATA_W-1:0] r_result_data;
    logic [CNT_W-1:0]  r_result_index;
    logic              r_missed;

    logic              w_emit;
    logic [ACC_W-1:0]  w_acc_shift;
    logic [7:0]        w_samples_next;
    logic              w_point_full;
    logic              w_last_point;
    logic [2:0]        w_resume_state;
    logic [GAP_W-1:0]  w_gap_load;

    assign w_emit         = (r_state == S_EMIT) && !abort;
    assign w_acc_shift    = r_acc >> r_avg_log2;
    assign w_samples_next = r_samples + 8'd1;
    assign w_point_full   = (w_samples_next == (8'd1 << r_avg_log2));
    assign w_last_point   = (r_index == (r_num_points - CNT_W'(1)));
    assign w_resume_state = (r_gap == '0) ? S_ISSUE : S_GAP;
    assign w_gap_load     = r_gap - GAP_W'(1);

    // Strobes are combinational so an abort can veto them in the same cycle.
    assign daq_start     = (r_state == S_ISSUE) && !abort;
    assign daq_dac_code  = r_code;
    assign result_valid  = w_emit;
    assign result_data   = w_emit ? w_acc_shift[DATA_W-1:0] : r_result_data;
    assign result_index  = w_emit ? r_index : r_result_index;
    assign busy          = (r_state != S_IDLE);
    assign sweep_done    = (r_state == S_FINISH);
    assign missed_sample = r_missed;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_code         <= '0;
            r_step         <= '0;
            r_num_points   <= '0;
            r_index        <= '0;
            r_avg_log2     <= '0;
            r_gap          <= '0;
            r_gap_cnt      <= '0;
            r_acc          <= '0;
            r_samples      <= '0;
            r_got_valid    <= 1'b0;
            r_result_data  <= '0;
            r_result_index <= '0;
            r_missed       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (sweep_start && !abort) begin
                        r_code       <= cfg_start_code;
                        r_step       <= cfg_step;
                        r_num_points <= cfg_num_points;
                        r_avg_log2   <= cfg_avg_log2;
                        r_gap        <= cfg_gap;
                        r_index      <= '0;
                        r_acc        <= '0;
                        r_samples    <= '0;
                        r_missed     <= 1'b0;
                        r_state      <= (cfg_num_points == '0) ? S_FINISH : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_got_valid <= 1'b0;
                    r_state     <= abort ? S_IDLE : S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (daq_adc_valid) begin
                        r_acc       <= r_acc + ACC_W'(daq_adc_data);
                        r_got_valid <= 1'b1;
                    end
                    // A done coinciding with abort closes the transaction; nothing to drain.
                    if (abort) begin
                        r_state <= daq_done ? S_IDLE : S_DRAIN;
                    end else if (daq_done) begin
                        r_samples <= w_samples_next;
                        if (!daq_adc_valid && !r_got_valid) begin
                            r_missed <= 1'b1;
                        end
                        if (w_point_full) begin
                            r_state <= S_EMIT;
                        end else begin
                            r_state   <= w_resume_state;
                            r_gap_cnt <= w_gap_load;
                        end
                    end
                end
                S_GAP: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else if (r_gap_cnt == '0) begin
                        r_state <= S_ISSUE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_W'(1);
                    end
                end
                S_EMIT: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_result_data  <= w_acc_shift[DATA_W-1:0];
                        r_result_index <= r_index;
                        r_acc          <= '0;
                        r_samples      <= '0;
                        if (w_last_point) begin
                            r_state <= S_FINISH;
                        end else begin
                            r_index   <= r_index + CNT_W'(1);
                            r_code    <= r_code + r_step;
                            r_state   <= w_resume_state;
                            r_gap_cnt <= w_gap_load;
                        end
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                S_DRAIN: begin
                    if (daq_done) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_daq_sweep_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_daq_sweep_sequencer
// Purpose  : DAQ controller stand-in plus event-level sweep model for the sequencer.
// Revision : 1.0
// ============================================================================
module tb_daq_sweep_sequencer;

    localparam int DATA_W = 12;
    localparam int CNT_W  = 8;
    localparam int GAP_W  = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              sweep_start = 1'b0;
    logic              abort = 1'b0;
    logic [DATA_W-1:0] cfg_start_code = '0;
    logic [DATA_W-1:0] cfg_step = '0;
    logic [CNT_W-1:0]  cfg_num_points = '0;
    logic [2:0]        cfg_avg_log2 = '0;
    logic [GAP_W-1:0]  cfg_gap = '0;
    logic              daq_start;
    logic [DATA_W-1:0] daq_dac_code;
    logic              daq_adc_valid = 1'b0;
    logic [DATA_W-1:0] daq_adc_data = '0;
    logic              daq_done = 1'b0;
    logic              result_valid;
    logic [DATA_W-1:0] result_data;
    logic [CNT_W-1:0]  result_index;
    logic              busy;
    logic              sweep_done;
    logic              missed_sample;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    daq_sweep_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) u_dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .sweep_start    (sweep_start),
        .abort          (abort),
        .cfg_start_code (cfg_start_code),
        .cfg_step       (cfg_step),
        .cfg_num_points (cfg_num_points),
        .cfg_avg_log2   (cfg_avg_log2),
        .cfg_gap        (cfg_gap),
        .daq_start      (daq_start),
        .daq_dac_code   (daq_dac_code),
        .daq_adc_valid  (daq_adc_valid),
        .daq_adc_data   (daq_adc_data),
        .daq_done       (daq_done),
        .result_valid   (result_valid),
        .result_data    (result_data),
        .result_index   (result_index),
        .busy           (busy),
        .sweep_done     (sweep_done),
        .missed_sample  (missed_sample)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    // DAQ controller stand-in: done arrives bfm_lat cycles after the start pulse.
    int bfm_lat   = 3;
    bit bfm_early = 1'b0;
    bit bfm_drop  = 1'b0;
    int adc_q[$];

    initial begin : p_bfm
        logic [DATA_W-1:0] val;
        forever begin
            @(negedge clk);
            if (daq_start) begin
                if (adc_q.size() > 0) val = DATA_W'(adc_q.pop_front());
                else                  val = daq_dac_code;
                repeat (bfm_lat - 1) @(posedge clk);
                #1;
                if (bfm_early && !bfm_drop) begin
                    daq_adc_valid = 1'b1;
                    daq_adc_data  = val;
                end
                @(posedge clk);
                #1;
                daq_done      = 1'b1;
                daq_adc_valid = !bfm_early && !bfm_drop;
                daq_adc_data  = val;
                @(posedge clk);
                #1;
                daq_done      = 1'b0;
                daq_adc_valid = 1'b0;
            end
        end
    end

    // Sweep model: expected event cycles derived from the schedule rules.
    int cyc = 0;
    bit m_busy = 0, m_missed = 0, m_active = 0, m_drain = 0, m_out = 0, m_vseen = 0;
    bit was_busy, prev_busy = 0;
    int m_vsum = 0;
    int m_start = 0, m_step = 0, m_points = 0, m_avg = 0, m_gap = 0;
    int m_starts = 0, m_dones = 0, m_results = 0;
    int m_hold_data = 0, m_hold_idx = 0;
    int exp_start_cyc = -1, exp_res_cyc = -1, exp_sd_cyc = -1;
    int samp[$];
    int code_log[$], start_log[$], done_log[$], rdata_log[$], ridx_log[$];
    int sd_count = 0, sd_cyc = -1, accept_cyc = -1, fall_cyc = -1;

    always @(negedge clk) begin : p_model
        int n, sum, exp_val;
        cyc++;
        was_busy = m_busy;
        chk("busy", longint'(busy), longint'(m_busy));
        chk("missed_sample", longint'(missed_sample), longint'(m_missed));
        if (prev_busy && !busy) fall_cyc = cyc;
        prev_busy = busy;

        if (exp_start_cyc == cyc) chk("daq_start_pulse", longint'(daq_start), 1);
        if (daq_start) begin
            exp_val = (m_start + (m_starts >> m_avg) * m_step) % (1 << DATA_W);
            chk("daq_start_cycle", cyc, exp_start_cyc);
            chk("daq_dac_code", longint'(daq_dac_code), exp_val);
            code_log.push_back(int'(daq_dac_code));
            start_log.push_back(cyc);
            m_starts++;
            m_out = 1; m_vseen = 0; m_vsum = 0;
        end

        if (daq_adc_valid && m_out) begin
            m_vseen = 1;
            m_vsum += int'(daq_adc_data);
        end

        if (daq_done && m_out) begin
            m_out = 0;
            done_log.push_back(cyc);
            if (m_drain) begin
                m_drain = 0;
                m_busy  = 0;
            end else begin
                if (!m_vseen) m_missed = 1;
                samp.push_back(m_vseen ? m_vsum : 0);
                m_dones++;
                if (m_dones % (1 << m_avg) == 0) exp_res_cyc = cyc + 1;
                else                             exp_start_cyc = cyc + 1 + m_gap;
            end
        end

        if (exp_res_cyc == cyc) chk("result_valid_pulse", longint'(result_valid), 1);
        if (result_valid) begin
            n = 1 << m_avg;
            sum = 0;
            for (int j = 0; j < n; j++)
                if (m_results * n + j < samp.size()) sum += samp[m_results * n + j];
            exp_val = (sum >> m_avg) % (1 << DATA_W);
            chk("result_cycle", cyc, exp_res_cyc);
            chk("result_data", longint'(result_data), exp_val);
            chk("result_index", longint'(result_index), m_results);
            rdata_log.push_back(int'(result_data));
            ridx_log.push_back(int'(result_index));
            m_hold_data = exp_val;
            m_hold_idx  = m_results;
            m_results++;
            if (m_results == m_points) exp_sd_cyc = cyc + 1;
            else                       exp_start_cyc = cyc + 1 + m_gap;
        end else begin
            chk("result_data_hold", longint'(result_data), m_hold_data);
            chk("result_index_hold", longint'(result_index), m_hold_idx);
        end

        if (exp_sd_cyc == cyc) begin
            chk("sweep_done_pulse", longint'(sweep_done), 1);
            m_busy = 0;
            m_active = 0;
        end
        if (sweep_done) begin
            chk("sweep_done_cycle", cyc, exp_sd_cyc);
            sd_count++;
            sd_cyc = cyc;
        end

        if (exp_start_cyc == cyc) exp_start_cyc = -1;
        if (exp_res_cyc == cyc)   exp_res_cyc = -1;
        if (exp_sd_cyc == cyc)    exp_sd_cyc = -1;

        if (reset_n && abort && m_active) begin
            m_active = 0;
            exp_start_cyc = -1; exp_res_cyc = -1; exp_sd_cyc = -1;
            if (m_out) m_drain = 1;
            else       m_busy = 0;
        end

        if (reset_n && !was_busy && sweep_start && !abort) begin
            m_busy = 1; m_active = 1; m_missed = 0; m_out = 0; m_drain = 0;
            m_start  = int'(cfg_start_code);
            m_step   = int'(cfg_step);
            m_points = int'(cfg_num_points);
            m_avg    = int'(cfg_avg_log2);
            m_gap    = int'(cfg_gap);
            m_starts = 0; m_dones = 0; m_results = 0;
            samp.delete(); code_log.delete(); start_log.delete(); done_log.delete();
            rdata_log.delete(); ridx_log.delete();
            sd_count = 0; sd_cyc = -1; fall_cyc = -1; accept_cyc = cyc;
            if (m_points == 0) exp_sd_cyc = cyc + 1;
            else               exp_start_cyc = cyc + 1;
        end

        if (!reset_n) begin
            m_busy = 0; m_missed = 0; m_active = 0; m_drain = 0; m_out = 0;
            m_hold_data = 0; m_hold_idx = 0;
            exp_start_cyc = -1; exp_res_cyc = -1; exp_sd_cyc = -1;
        end
    end

    task automatic begin_sweep(input int st, input int sp, input int np, input int av, input int gp);
        @(posedge clk); #1;
        cfg_start_code = DATA_W'(st);
        cfg_step       = DATA_W'(sp);
        cfg_num_points = CNT_W'(np);
        cfg_avg_log2   = 3'(av);
        cfg_gap        = GAP_W'(gp);
        sweep_start    = 1'b1;
        @(posedge clk); #1;
        sweep_start    = 1'b0;
        cfg_start_code = 12'hABC;
        cfg_step       = 12'h777;
        cfg_num_points = 8'd9;
        cfg_avg_log2   = 3'd5;
        cfg_gap        = 16'd3;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        @(negedge clk);
        while (busy && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("sweep_terminates", longint'(busy), 0);
        @(posedge clk); #1;
    endtask

    task automatic run_sweep(input int st, input int sp, input int np, input int av, input int gp);
        begin_sweep(st, sp, np, av, gp);
        wait_idle(4000);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, longint'(busy), 0);
        chk({tag, "_daq_start"}, longint'(daq_start), 0);
        chk({tag, "_daq_dac_code"}, longint'(daq_dac_code), 0);
        chk({tag, "_result_valid"}, longint'(result_valid), 0);
        chk({tag, "_result_data"}, longint'(result_data), 0);
        chk({tag, "_result_index"}, longint'(result_index), 0);
        chk({tag, "_sweep_done"}, longint'(sweep_done), 0);
        chk({tag, "_missed_sample"}, longint'(missed_sample), 0);
    endtask

    initial begin : p_watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : p_main
        int k;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        reset_n = 1'b1;

        // Basic three-point sweep, ADC echoes the DAC code
        bfm_lat = 3; bfm_early = 1'b0;
        run_sweep(32'h100, 32'h010, 3, 0, 0);
        chk("t1_nres", rdata_log.size(), 3);
        chk("t1_res0", qget(rdata_log, 0), 32'h100);
        chk("t1_res1", qget(rdata_log, 1), 32'h110);
        chk("t1_res2", qget(rdata_log, 2), 32'h120);
        chk("t1_idx2", qget(ridx_log, 2), 2);
        chk("t1_starts", start_log.size(), 3);
        chk("t1_sweep_done", sd_count, 1);
        chk("t1_busy_after", longint'(busy), 0);

        // Four-sample average with gap 0
        adc_q = '{10, 11, 12, 14};
        run_sweep(32'h200, 1, 1, 2, 0);
        chk("t2_res0", qget(rdata_log, 0), 11);
        chk("t2_starts", start_log.size(), 4);
        chk("t2_gap0_spacing", qget(start_log, 1) - qget(done_log, 0), 1);

        // DAC code wrap
        run_sweep(32'hFF0, 32'h020, 2, 0, 1);
        chk("t3_code0", qget(code_log, 0), 32'hFF0);
        chk("t3_code1", qget(code_log, 1), 32'h010);
        chk("t3_res1", qget(rdata_log, 1), 32'h010);

        // Gap of 5 with valid ahead of done
        bfm_lat = 4; bfm_early = 1'b1;
        run_sweep(32'h050, 32'h100, 2, 1, 5);
        chk("t4_gap_within_point", qget(start_log, 1) - qget(done_log, 0), 6);
        chk("t4_gap_across_point", qget(start_log, 2) - qget(done_log, 1), 7);
        chk("t4_res1", qget(rdata_log, 1), 32'h150);
        chk("t4_starts", start_log.size(), 4);

        // Abort during an open transaction
        bfm_lat = 6; bfm_early = 1'b0;
        begin_sweep(32'h300, 32'h010, 4, 0, 0);
        k = 0;
        @(negedge clk);
        while (!daq_start && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("t5_first_start_seen", longint'(daq_start), 1);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        wait_idle(200);
        chk("t5_starts", start_log.size(), 1);
        chk("t5_results", rdata_log.size(), 0);
        chk("t5_sweep_done", sd_count, 0);
        chk("t5_busy_until_done", fall_cyc - qget(done_log, 0), 1);

        // Empty sweep
        run_sweep(32'h123, 1, 0, 0, 0);
        chk("t6_sweep_done", sd_count, 1);
        chk("t6_sd_latency", sd_cyc - accept_cyc, 1);
        chk("t6_starts", start_log.size(), 0);

        // Missing ADC data, then cleared by the next sweep
        bfm_lat = 2; bfm_drop = 1'b1;
        run_sweep(32'h040, 0, 1, 0, 0);
        chk("t7_missed_set", longint'(missed_sample), 1);
        chk("t7_res0", qget(rdata_log, 0), 0);
        bfm_drop = 1'b0;
        begin_sweep(32'h060, 32'h001, 2, 0, 0);
        @(negedge clk);
        chk("t7_missed_cleared", longint'(missed_sample), 0);
        wait_idle(400);

        // Reset in the middle of a sweep
        begin_sweep(32'h700, 32'h011, 3, 1, 3);
        k = 0;
        @(negedge clk);
        while (!result_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("t8_first_result_seen", longint'(result_valid), 1);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check_all_zero("midreset");
        repeat (20) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
